// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter: FSM states and
// the encodings presented on the grant output.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_I    = 2'b01;
    localparam logic [1:0] GRANT_D    = 2'b10;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction (read-only) master and a data master onto one shared
// memory port; data wins ties unless the instruction master has waited STARVE_MAX grants.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_read_en,
    input  logic [DATA_W/8-1:0] i_byteenable,
    output logic [DATA_W-1:0]   i_readdata,
    output logic                i_waitrequest,

    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_writedata,
    input  logic                d_read_en,
    input  logic                d_write_en,
    input  logic [DATA_W/8-1:0] d_byteenable,
    output logic [DATA_W-1:0]   d_readdata,
    output logic                d_waitrequest,

    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_writedata,
    output logic                m_read_en,
    output logic                m_write_en,
    output logic [DATA_W/8-1:0] m_byteenable,
    input  logic [DATA_W-1:0]   m_readdata,
    input  logic                m_waitrequest,

    output logic [1:0]          grant
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_t       r_state;
    arb_state_t       w_next_state;
    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_i_req;
    logic             w_d_req;

    assign w_i_req = i_read_en;
    assign w_d_req = d_read_en | d_write_en;

    // NOTE: non-blocking assignments here so every flop samples pre-edge values together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_next_state;
            r_starve_cnt <= w_next_cnt;
        end
    end

    // Arbitration only happens from IDLE; a grant is held until the memory accepts.
    always_comb begin
        // NOTE: defaults first so no branch leaves a signal unassigned and infers a latch.
        w_next_state = r_state;
        w_next_cnt   = r_starve_cnt;
        case (r_state)
            IDLE: begin
                if (w_d_req && ((r_starve_cnt < STARVE_LIM) || !w_i_req)) begin
                    w_next_state = GNT_D;
                    if (!w_i_req)
                        w_next_cnt = '0;
                    else if (r_starve_cnt != STARVE_LIM)
                        w_next_cnt = r_starve_cnt + CNT_W'(1);
                end else if (w_i_req) begin
                    w_next_state = GNT_I;
                    w_next_cnt   = '0;
                end
            end
            GNT_I, GNT_D: begin
                if (!m_waitrequest)
                    w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Requests are forwarded unfiltered, including a data read+write pair.
    always_comb begin
        m_addr        = '0;
        m_writedata   = '0;
        m_read_en     = 1'b0;
        m_write_en    = 1'b0;
        m_byteenable  = '0;
        i_waitrequest = 1'b1;
        d_waitrequest = 1'b1;
        grant         = GRANT_NONE;
        case (r_state)
            GNT_I: begin
                m_addr        = i_addr;
                m_read_en     = i_read_en;
                m_byteenable  = i_byteenable;
                i_waitrequest = m_waitrequest;
                grant         = GRANT_I;
            end
            GNT_D: begin
                m_addr        = d_addr;
                m_writedata   = d_writedata;
                m_read_en     = d_read_en;
                m_write_en    = d_write_en;
                m_byteenable  = d_byteenable;
                d_waitrequest = m_waitrequest;
                grant         = GRANT_D;
            end
            default: ;
        endcase
    end

    assign i_readdata = m_readdata;
    assign d_readdata = m_readdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter plus directed corner cases
// (zero-wait read, tie, starvation, wait states, async reset, dropped request).
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int STARVE_MAX = 4;
    localparam int N_RAND     = 1500;

    logic        clk;
    logic        reset;
    logic [31:0] i_addr, i_readdata;
    logic        i_read_en, i_waitrequest;
    logic [3:0]  i_byteenable;
    logic [31:0] d_addr, d_writedata, d_readdata;
    logic        d_read_en, d_write_en, d_waitrequest;
    logic [3:0]  d_byteenable;
    logic [31:0] m_addr, m_writedata, m_readdata;
    logic        m_read_en, m_write_en, m_waitrequest;
    logic [3:0]  m_byteenable;
    logic [1:0]  grant;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .i_addr(i_addr), .i_read_en(i_read_en), .i_byteenable(i_byteenable),
        .i_readdata(i_readdata), .i_waitrequest(i_waitrequest),
        .d_addr(d_addr), .d_writedata(d_writedata), .d_read_en(d_read_en),
        .d_write_en(d_write_en), .d_byteenable(d_byteenable),
        .d_readdata(d_readdata), .d_waitrequest(d_waitrequest),
        .m_addr(m_addr), .m_writedata(m_writedata), .m_read_en(m_read_en),
        .m_write_en(m_write_en), .m_byteenable(m_byteenable),
        .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
        .grant(grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic [1:0]  grant;
        logic        iw;
        logic        dw;
        logic [31:0] rdata;
    } cyc_t;

    typedef struct packed {
        logic [1:0]  who;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
        logic [3:0]  be;
    } txn_t;

    cyc_t cyc_q[$];
    txn_t txn_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        i_addr = '0; i_read_en = 1'b0; i_byteenable = '0;
        d_addr = '0; d_writedata = '0; d_read_en = 1'b0; d_write_en = 1'b0; d_byteenable = '0;
        m_readdata = '0; m_waitrequest = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: one expected entry per cycle, one expected transfer per completion.
    initial begin
        cyc_t ce;
        txn_t te;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                if (cyc_q.size() == 0) begin
                    check("cyc_q_underflow", 1, 0);
                end else begin
                    ce = cyc_q.pop_front();
                    check("grant", grant, ce.grant);
                    check("i_waitrequest", i_waitrequest, ce.iw);
                    check("d_waitrequest", d_waitrequest, ce.dw);
                    check("i_readdata", i_readdata, ce.rdata);
                    check("d_readdata", d_readdata, ce.rdata);
                    if (ce.grant == GRANT_NONE) begin
                        check("idle_m_ctrl", {m_read_en, m_write_en, m_byteenable}, 0);
                        check("idle_m_addr_data", {m_addr, m_writedata}, 0);
                    end
                end
                if (!i_waitrequest || !d_waitrequest) begin
                    if (txn_q.size() == 0) begin
                        check("txn_q_underflow", 1, 0);
                    end else begin
                        te = txn_q.pop_front();
                        check("txn_master", grant, te.who);
                        check("txn_addr", m_addr, te.addr);
                        check("txn_wdata", m_writedata, te.wdata);
                        check("txn_rd_wr", {m_read_en, m_write_en}, {te.rd, te.wr});
                        check("txn_be", m_byteenable, te.be);
                    end
                end
            end
        end
    end

    // Reference model state: who currently owns the port and how many data grants
    // in a row have been given while the instruction master was waiting.
    logic [1:0]  owner;
    int          streak;
    logic        i_pend, d_pend, d_rd, d_wr;
    logic [31:0] i_a, d_a, d_w;
    logic [3:0]  i_b, d_b;
    logic [1:0]  seen [10];
    logic [1:0]  exp_seq [10];
    int          n_seen;

    initial begin
        int k;
        // NOTE: stimulus uses blocking assignments, applied on the falling edge.
        reset = 1'b1;
        i_addr = 32'h1; i_read_en = 1'b1; i_byteenable = 4'hF;
        d_addr = 32'h2; d_writedata = 32'h3; d_read_en = 1'b1; d_write_en = 1'b1; d_byteenable = 4'hF;
        m_readdata = 32'h0; m_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_grant", grant, GRANT_NONE);
        check("rst_m_en", {m_read_en, m_write_en}, 2'b00);
        check("rst_waitreq", {i_waitrequest, d_waitrequest}, 2'b11);

        // ---------------- randomized phase ----------------
        @(negedge clk);
        reset = 1'b0;
        owner = GRANT_NONE; streak = 0; i_pend = 1'b0; d_pend = 1'b0;
        i_a = '0; i_b = '0; d_a = '0; d_w = '0; d_b = '0; d_rd = 1'b0; d_wr = 1'b0;
        mon_en = 1'b1;
        for (int c = 0; c < N_RAND; c++) begin
            if (c > 0) @(negedge clk);
            if (!i_pend && $urandom_range(0, 99) < 35) begin
                i_pend = 1'b1; i_a = $urandom; i_b = 4'($urandom);
            end
            if (!d_pend && $urandom_range(0, 99) < 45) begin
                d_pend = 1'b1; d_a = $urandom; d_w = $urandom; d_b = 4'($urandom);
                k = $urandom_range(0, 4);
                d_rd = (k < 2) || (k == 4);
                d_wr = (k >= 2);
            end
            i_read_en    = i_pend;
            i_addr       = i_pend ? i_a : $urandom;
            i_byteenable = i_pend ? i_b : 4'($urandom);
            d_read_en    = d_pend && d_rd;
            d_write_en   = d_pend && d_wr;
            d_addr       = d_pend ? d_a : $urandom;
            d_writedata  = d_pend ? d_w : $urandom;
            d_byteenable = d_pend ? d_b : 4'($urandom);
            m_waitrequest = ($urandom_range(0, 99) < 35);
            m_readdata    = $urandom;

            cyc_q.push_back('{grant: owner,
                              iw: !(owner == GRANT_I && !m_waitrequest),
                              dw: !(owner == GRANT_D && !m_waitrequest),
                              rdata: m_readdata});

            if (owner == GRANT_NONE) begin
                if (d_pend && (streak < STARVE_MAX || !i_pend)) begin
                    owner  = GRANT_D;
                    streak = !i_pend ? 0 : (streak < STARVE_MAX ? streak + 1 : STARVE_MAX);
                    txn_q.push_back('{who: GRANT_D, addr: d_a, wdata: d_w, rd: d_rd, wr: d_wr, be: d_b});
                end else if (i_pend) begin
                    owner  = GRANT_I;
                    streak = 0;
                    txn_q.push_back('{who: GRANT_I, addr: i_a, wdata: 32'h0, rd: 1'b1, wr: 1'b0, be: i_b});
                end
            end else if (!m_waitrequest) begin
                if (owner == GRANT_I) i_pend = 1'b0;
                else                  d_pend = 1'b0;
                owner = GRANT_NONE;
            end
        end
        @(negedge clk);
        mon_en = 1'b0;
        check("end_cyc_q_empty", cyc_q.size(), 0);
        check("end_txn_q_left", txn_q.size(), (owner != GRANT_NONE) ? 1 : 0);
        txn_q.delete();

        // ---------------- zero-wait instruction read ----------------
        do_reset();
        i_read_en = 1'b1; i_addr = 32'h100; i_byteenable = 4'hF;
        m_waitrequest = 1'b0; m_readdata = 32'hDEADBEEF;
        #1;
        check("ionly_c0_grant", grant, GRANT_NONE);
        check("ionly_c0_m_rd", m_read_en, 1'b0);
        @(negedge clk); #1;
        check("ionly_c1_grant", grant, GRANT_I);
        check("ionly_c1_m_rd", m_read_en, 1'b1);
        check("ionly_c1_m_addr", m_addr, 32'h100);
        check("ionly_c1_iwait", i_waitrequest, 1'b0);
        check("ionly_c1_rdata", i_readdata, 32'hDEADBEEF);
        i_read_en = 1'b0;
        @(negedge clk); #1;
        check("ionly_c2_idle", grant, GRANT_NONE);

        // ---------------- simultaneous requests ----------------
        do_reset();
        d_write_en = 1'b1; d_addr = 32'h200; d_writedata = 32'h12345678; d_byteenable = 4'hF;
        i_read_en = 1'b1; i_addr = 32'h104; i_byteenable = 4'hF;
        @(negedge clk); #1;
        check("tie_c1_grant", grant, GRANT_D);
        check("tie_c1_m_wr", m_write_en, 1'b1);
        check("tie_c1_m_wdata", m_writedata, 32'h12345678);
        check("tie_c1_m_addr", m_addr, 32'h200);
        check("tie_c1_waits", {i_waitrequest, d_waitrequest}, 2'b10);
        d_write_en = 1'b0;
        @(negedge clk); #1;
        check("tie_c2_idle", grant, GRANT_NONE);
        @(negedge clk); #1;
        check("tie_c3_grant", grant, GRANT_I);
        check("tie_c3_m_addr", m_addr, 32'h104);
        i_read_en = 1'b0;

        // ---------------- starvation limit ----------------
        do_reset();
        d_read_en = 1'b1; d_addr = 32'h500; i_read_en = 1'b1; i_addr = 32'h600;
        m_waitrequest = 1'b0;
        exp_seq = '{GRANT_D, GRANT_D, GRANT_D, GRANT_D, GRANT_I,
                    GRANT_D, GRANT_D, GRANT_D, GRANT_D, GRANT_I};
        for (int j = 0; j < 10; j++) seen[j] = GRANT_NONE;
        n_seen = 0;
        for (int c = 0; c < 40 && n_seen < 10; c++) begin
            @(negedge clk); #1;
            if (grant != GRANT_NONE) begin
                seen[n_seen] = grant;
                n_seen++;
            end
        end
        check("starve_grants_seen", n_seen, 10);
        for (int j = 0; j < 10; j++)
            check($sformatf("starve_seq_%0d", j), seen[j], exp_seq[j]);
        d_read_en = 1'b0; i_read_en = 1'b0;

        // ---------------- wait states ----------------
        do_reset();
        d_read_en = 1'b1; d_addr = 32'h300; d_byteenable = 4'h3;
        i_read_en = 1'b1; i_addr = 32'h700; m_waitrequest = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); #1;
            check($sformatf("ws_c%0d_grant", c), grant, GRANT_D);
            check($sformatf("ws_c%0d_m", c), {m_addr, m_read_en, m_byteenable}, {32'h300, 1'b1, 4'h3});
            check($sformatf("ws_c%0d_waits", c), {i_waitrequest, d_waitrequest}, 2'b11);
        end
        @(negedge clk);
        m_waitrequest = 1'b0;
        #1;
        check("ws_c4_grant", grant, GRANT_D);
        check("ws_c4_waits", {i_waitrequest, d_waitrequest}, 2'b10);
        d_read_en = 1'b0;
        @(negedge clk); #1;
        check("ws_c5_idle", grant, GRANT_NONE);
        @(negedge clk); #1;
        check("ws_c6_instr", grant, GRANT_I);
        i_read_en = 1'b0;

        // ---------------- asynchronous reset mid-transfer ----------------
        do_reset();
        d_write_en = 1'b1; d_addr = 32'h400; d_writedata = 32'hA5A5A5A5; d_byteenable = 4'hF;
        m_waitrequest = 1'b1;
        @(negedge clk); #1;
        check("arst_pre_grant", grant, GRANT_D);
        check("arst_pre_m_wr", m_write_en, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_m_wr", m_write_en, 1'b0);
        check("arst_grant", grant, GRANT_NONE);
        check("arst_waits", {i_waitrequest, d_waitrequest}, 2'b11);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("arst_release_idle", grant, GRANT_NONE);
        @(negedge clk); #1;
        check("arst_first_arb", grant, GRANT_D);
        d_write_en = 1'b0; m_waitrequest = 1'b0;
        @(negedge clk); #1;
        check("arst_done_idle", grant, GRANT_NONE);

        // ---------------- request dropped mid-transfer ----------------
        do_reset();
        d_read_en = 1'b1; d_addr = 32'h800; m_waitrequest = 1'b1;
        @(negedge clk); #1;
        check("drop_c1_grant", grant, GRANT_D);
        d_read_en = 1'b0;
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk); #1;
            check($sformatf("drop_c%0d_grant", c), grant, GRANT_D);
            check($sformatf("drop_c%0d_m_rd", c), m_read_en, 1'b0);
            check($sformatf("drop_c%0d_dwait", c), d_waitrequest, 1'b1);
        end
        @(negedge clk);
        m_waitrequest = 1'b0;
        #1;
        check("drop_c4_grant", grant, GRANT_D);
        check("drop_c4_dwait", d_waitrequest, 1'b0);
        @(negedge clk); #1;
        check("drop_c5_idle", grant, GRANT_NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have parameter STARVE_MAX, default 4, maximum consecutive data grants while instr waits.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 i_addr in ADDR_W; i_read_en in 1; i_byteenable in DATA_W/8; i_readdata out DATA_W; i_waitrequest out 1. Instruction master, read-only.
REQ-007 d_addr in ADDR_W; d_writedata in DATA_W; d_read_en in 1; d_write_en in 1; d_byteenable in DATA_W/8; d_readdata out DATA_W; d_waitrequest out 1. Data master.
REQ-008 m_addr out ADDR_W; m_writedata out DATA_W; m_read_en out 1; m_write_en out 1; m_byteenable out DATA_W/8; m_readdata in DATA_W; m_waitrequest in 1. Shared memory port.
REQ-009 grant out 2: 2'b00 none, 2'b01 instr, 2'b10 data.

Function
REQ-010 SHALL implement FSM states IDLE, GNT_I, GNT_D, registered.
REQ-011 Request definitions: i_req = i_read_en; d_req = d_read_en | d_write_en.
REQ-012 IDLE: if d_req and (starve_cnt < STARVE_MAX or !i_req), go to GNT_D. Else if i_req, go to GNT_I. Else stay in IDLE.
REQ-013 IDLE with both requests present and starve_cnt == STARVE_MAX: go to GNT_I.
REQ-014 In GNT_x, m_* outputs SHALL be a combinational mux of master x's address, writedata, read_en, write_en and byteenable.
REQ-015 In IDLE, m_read_en = m_write_en = 0, and m_addr, m_writedata and m_byteenable SHALL be 0.
REQ-016 i_waitrequest SHALL be 0 only in GNT_I with m_waitrequest == 0; otherwise 1.
REQ-017 d_waitrequest SHALL be 0 only in GNT_D with m_waitrequest == 0; otherwise 1.
REQ-018 i_readdata and d_readdata SHALL both be wired to m_readdata.
REQ-019 Completion: GNT_x with m_waitrequest == 0 returns to IDLE next cycle. Each transfer costs 1 arbitration cycle plus the memory cycles.
REQ-020 Grant SHALL be held until completion, even if the granted master drops its request mid-transfer. Master protocol violations are not masked.
REQ-021 Latency: a request seen in IDLE at edge N drives the m_* port in cycle N+1. With zero-wait memory, completion is in cycle N+1.
REQ-022 starve_cnt, 0..STARVE_MAX saturating, updates on each entry to GNT_D or GNT_I:
  - entry to GNT_D with i_req = 1: increment;
  - entry to GNT_D with i_req = 0: clear;
  - entry to GNT_I: clear.
REQ-023 A simultaneous read and write from the data master is forwarded unchanged and is not arbitrated.
REQ-024 grant SHALL reflect the current state.

Reset
REQ-025 Reset SHALL force, asynchronously:
  - state = IDLE, starve_cnt = 0, grant = 0;
  - m_read_en = m_write_en = 0;
  - i_waitrequest = d_waitrequest = 1.
REQ-026 Reset asserted mid-transfer SHALL abandon the transfer; no completion is signalled to either master.
REQ-027 After reset deasserts, the first arbitration SHALL occur on the first rising edge with reset low.

Structure
REQ-028 Package mem_arb_pkg SHALL hold the state enum (IDLE, GNT_I, GNT_D) and the grant encodings GRANT_NONE, GRANT_I and GRANT_D.
REQ-029 The block SHALL be a single module with no sub-modules. The FSM, starvation counter and output mux are inline.

Verification
REQ-030 Instr-only: i_read_en = 1, i_addr = 0x100, m_waitrequest = 0, m_readdata = 0xDEADBEEF -> m_read_en = 1 and m_addr = 0x100 in cycle 1; i_waitrequest = 0 and i_readdata = 0xDEADBEEF in cycle 1; IDLE in cycle 2.
REQ-031 Simultaneous: d_write_en = 1 (addr 0x200, data 0x12345678) and i_read_en = 1 in the same cycle -> data granted first, m_write_en = 1 with m_writedata = 0x12345678; instr granted on the next arbitration.
REQ-032 Starvation: d_read_en and i_read_en both held high -> grant sequence D,D,D,D,I,D,D,D,D,I; STARVE_MAX = 4.
REQ-033 Wait states: m_waitrequest = 1 for 3 cycles during GNT_D -> m_* stable and d_waitrequest = 1 throughout; completion on cycle 4; i_waitrequest = 1 throughout.
REQ-034 Async reset: assert reset mid-GNT_D, off-edge -> m_write_en and grant drop immediately without a clock; state = IDLE after release.
REQ-035 Dropped request: d_read_en falls while m_waitrequest = 1 -> grant stays GNT_D until m_waitrequest = 0, then IDLE.
